// File: rtl/lsq_request_issuer.sv
// -----------------------------------------------------------------------------
// lsq_request_issuer
//
// Consumer end of the load/store queue. Each cycle it may pop one LSQ entry
// into a single-entry request register that drives the data-memory request
// handshake. Loads are remembered in an in-order tracking FIFO so the returned
// read word can be aligned and extended and tagged with its instruction ID
// for writeback.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   lsq_valid/load/store/addr/be/fn3/data/id
//                       LSQ head entry; lsq_pop acknowledges it (combinational)
//   mem_req_valid/ready/rnw/addr/be/wdata
//                       data-memory request handshake (word-aligned address)
//   mem_rvalid/rdata    read responses, returned in request order
//   wb_valid/id/data    one-cycle load result towards writeback
//   outstanding_loads   loads popped but not yet written back
//   resp_error          sticky: a response arrived with no load tracked
// -----------------------------------------------------------------------------
module lsq_request_issuer #(
    parameter int ID_WIDTH              = 3,
    parameter int MAX_OUTSTANDING_LOADS = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   lsq_valid,
    input  logic                                   lsq_load,
    input  logic                                   lsq_store,
    input  logic [31:0]                            lsq_addr,
    input  logic [3:0]                             lsq_be,
    input  logic [2:0]                             lsq_fn3,
    input  logic [31:0]                            lsq_data,
    input  logic [ID_WIDTH-1:0]                    lsq_id,
    output logic                                   lsq_pop,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic                                   mem_req_rnw,
    output logic [31:0]                            mem_req_addr,
    output logic [3:0]                             mem_req_be,
    output logic [31:0]                            mem_req_wdata,
    input  logic                                   mem_rvalid,
    input  logic [31:0]                            mem_rdata,
    output logic                                   wb_valid,
    output logic [ID_WIDTH-1:0]                    wb_id,
    output logic [31:0]                            wb_data,
    output logic [$clog2(MAX_OUTSTANDING_LOADS):0] outstanding_loads,
    output logic                                   resp_error
);

    localparam int PTR_W   = $clog2(MAX_OUTSTANDING_LOADS);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ID_WIDTH + 3 + 2;

    // ---------------- request register ----------------
    logic        req_valid_reg;
    logic        req_rnw_reg;
    logic [31:0] req_addr_reg;
    logic [3:0]  req_be_reg;
    logic [31:0] req_wdata_reg;

    // ---------------- load tracking FIFO ----------------
    logic [ENTRY_W-1:0] track_mem [MAX_OUTSTANDING_LOADS];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;

    // ---------------- response path ----------------
    logic                wb_valid_reg;
    logic [ID_WIDTH-1:0] wb_id_reg;
    logic [31:0]         wb_data_reg;
    logic                resp_error_reg;

    logic                can_accept;
    logic                load_ok;
    logic                push;
    logic                retire;
    logic [ENTRY_W-1:0]  head;
    logic [ID_WIDTH-1:0] head_id;
    logic [2:0]          head_fn3;
    logic [1:0]          head_off;
    logic [31:0]         shifted;
    logic [31:0]         ext_data;

    // The register frees up in the same cycle its request is accepted, which
    // is what allows one request per cycle. load_ok uses only the registered
    // count: a response retiring this cycle does not make room until next.
    assign can_accept = ~req_valid_reg | mem_req_ready;
    assign load_ok    = count_reg < CNT_W'(MAX_OUTSTANDING_LOADS);
    assign lsq_pop    = lsq_valid & can_accept & (lsq_store | load_ok);
    assign push       = lsq_pop & lsq_load;
    assign retire     = mem_rvalid & (count_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_reg <= 1'b0;
        end else if (lsq_pop) begin
            req_valid_reg <= 1'b1;
            req_rnw_reg   <= lsq_load;
            req_addr_reg  <= {lsq_addr[31:2], 2'b00};
            req_be_reg    <= lsq_load ? 4'b1111 : lsq_be;
            req_wdata_reg <= lsq_data;
        end else if (mem_req_ready) begin
            req_valid_reg <= 1'b0;
        end
    end

    assign mem_req_valid = req_valid_reg;
    assign mem_req_rnw   = req_rnw_reg;
    assign mem_req_addr  = req_addr_reg;
    assign mem_req_be    = req_be_reg;
    assign mem_req_wdata = req_wdata_reg;

    // Storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            track_mem[wr_ptr_reg] <= {lsq_id, lsq_fn3, lsq_addr[1:0]};
        end
    end

    assign head     = track_mem[rd_ptr_reg];
    assign head_id  = head[ENTRY_W-1 -: ID_WIDTH];
    assign head_fn3 = head[4:2];
    assign head_off = head[1:0];

    always_comb begin
        count_next = count_reg;
        case ({push, retire})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (retire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    assign outstanding_loads = count_reg;

    // Bring the addressed byte/halfword down to lane 0, then extend. An
    // offset-3 halfword simply yields whatever the shift left behind.
    assign shifted = mem_rdata >> {head_off, 3'b000};

    always_comb begin
        ext_data = shifted;
        case (head_fn3)
            3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext_data = {24'd0, shifted[7:0]};
            3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext_data = {16'd0, shifted[15:0]};
            default: ext_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_reg   <= 1'b0;
            resp_error_reg <= 1'b0;
        end else begin
            wb_valid_reg <= retire;
            if (retire) begin
                wb_id_reg   <= head_id;
                wb_data_reg <= ext_data;
            end
            if (mem_rvalid && count_reg == '0) begin
                resp_error_reg <= 1'b1;
            end
        end
    end

    assign wb_valid   = wb_valid_reg;
    assign wb_id      = wb_id_reg;
    assign wb_data    = wb_data_reg;
    assign resp_error = resp_error_reg;

    // An LSQ entry must be exactly one of load or store.
    illegal_entry_kind_a: assert property (
        @(posedge clk) disable iff (rst) lsq_valid |-> (lsq_load ^ lsq_store)
    );

endmodule

// File: tb/tb_lsq_request_issuer.sv
module tb_lsq_request_issuer;

    localparam int IDW  = 3;
    localparam int MAXL = 4;

    logic        clk;
    logic        rst;
    logic        lsq_valid, lsq_load, lsq_store;
    logic [31:0] lsq_addr;
    logic [3:0]  lsq_be;
    logic [2:0]  lsq_fn3;
    logic [31:0] lsq_data;
    logic [IDW-1:0] lsq_id;
    logic        lsq_pop;
    logic        mem_req_valid, mem_req_ready, mem_req_rnw;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [IDW-1:0] wb_id;
    logic [31:0] wb_data;
    logic [2:0]  outstanding_loads;
    logic        resp_error;

    lsq_request_issuer #(.ID_WIDTH(IDW), .MAX_OUTSTANDING_LOADS(MAXL)) dut (
        .clk(clk), .rst(rst),
        .lsq_valid(lsq_valid), .lsq_load(lsq_load), .lsq_store(lsq_store),
        .lsq_addr(lsq_addr), .lsq_be(lsq_be), .lsq_fn3(lsq_fn3),
        .lsq_data(lsq_data), .lsq_id(lsq_id), .lsq_pop(lsq_pop),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
        .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
        .outstanding_loads(outstanding_loads), .resp_error(resp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [2:0]     fn3;
        logic [1:0]     off;
    } ld_t;

    ld_t         m_q[$];
    bit          model_on = 0;
    bit          m_req_valid;
    bit          m_rnw;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    bit          m_wb_valid;
    logic [IDW-1:0] m_wb_id;
    logic [31:0] m_wb_data;
    bit          m_err;

    function automatic logic [31:0] load_result(input logic [31:0] word,
                                                input logic [2:0] fn3,
                                                input logic [1:0] off);
        logic [31:0] s;
        logic [31:0] v;
        s = word >> (8 * int'(off));
        case (fn3)
            3'b000: begin v = s & 32'hFF;   return (v >= 32'd128)   ? v + 32'hFFFFFF00 : v; end
            3'b100: return s & 32'hFF;
            3'b001: begin v = s & 32'hFFFF; return (v >= 32'd32768) ? v + 32'hFFFF0000 : v; end
            3'b101: return s & 32'hFFFF;
            default: return s;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares every DUT output against the model, then advances the model
    // by one clock using the inputs that the coming edge will sample.
    task automatic model_cycle();
        bit  exp_pop;
        ld_t h;
        exp_pop = lsq_valid && (!m_req_valid || mem_req_ready) &&
                  (lsq_store || m_q.size() < MAXL);
        if (model_on) begin
            chk("m_lsq_pop", {31'd0, lsq_pop}, {31'd0, exp_pop});
            chk("m_req_valid", {31'd0, mem_req_valid}, {31'd0, m_req_valid});
            if (m_req_valid) begin
                chk("m_req_rnw", {31'd0, mem_req_rnw}, {31'd0, m_rnw});
                chk("m_req_addr", mem_req_addr, m_addr);
                chk("m_req_be", {28'd0, mem_req_be}, {28'd0, m_be});
                if (!m_rnw) chk("m_req_wdata", mem_req_wdata, m_wdata);
            end
            chk("m_wb_valid", {31'd0, wb_valid}, {31'd0, m_wb_valid});
            if (m_wb_valid) begin
                chk("m_wb_id", {29'd0, wb_id}, {29'd0, m_wb_id});
                chk("m_wb_data", wb_data, m_wb_data);
            end
            chk("m_outstanding", {29'd0, outstanding_loads}, 32'(m_q.size()));
            chk("m_resp_error", {31'd0, resp_error}, {31'd0, m_err});
        end
        if (rst) begin
            m_q.delete();
            m_req_valid = 0;
            m_wb_valid  = 0;
            m_err       = 0;
        end else begin
            m_wb_valid = 0;
            if (mem_rvalid) begin
                if (m_q.size() > 0) begin
                    h = m_q.pop_front();
                    m_wb_valid = 1;
                    m_wb_id    = h.id;
                    m_wb_data  = load_result(mem_rdata, h.fn3, h.off);
                end else begin
                    m_err = 1;
                end
            end
            if (exp_pop) begin
                m_req_valid = 1;
                m_rnw   = lsq_load;
                m_addr  = lsq_addr & 32'hFFFFFFFC;
                m_be    = lsq_load ? 4'hF : lsq_be;
                m_wdata = lsq_data;
                if (lsq_load) m_q.push_back('{id: lsq_id, fn3: lsq_fn3, off: lsq_addr[1:0]});
            end else if (mem_req_ready) begin
                m_req_valid = 0;
            end
        end
    endtask

    // Run the model at the falling edge, then return just after the next
    // rising edge so the caller can drive the following cycle's inputs.
    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        lsq_valid = 0; lsq_load = 0; lsq_store = 0;
        mem_rvalid = 0;
    endtask

    task automatic set_load(input logic [IDW-1:0] id, input logic [2:0] fn3, input logic [31:0] addr);
        lsq_valid = 1; lsq_load = 1; lsq_store = 0;
        lsq_id = id; lsq_fn3 = fn3; lsq_addr = addr; lsq_be = 4'h0; lsq_data = 32'h0;
    endtask

    task automatic set_store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        lsq_valid = 1; lsq_load = 0; lsq_store = 1;
        lsq_id = '0; lsq_fn3 = 3'b010; lsq_addr = addr; lsq_be = be; lsq_data = data;
    endtask

    task automatic respond(input logic [31:0] data);
        mem_rvalid = 1; mem_rdata = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; mem_req_ready = 1; mem_rdata = 0;
        lsq_addr = 0; lsq_be = 0; lsq_fn3 = 0; lsq_data = 0; lsq_id = 0;
        drive_idle();
        step();
        model_on = 1;
        step();
        rst = 0; #1;
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_lsq_pop", {31'd0, lsq_pop}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_outstanding", {29'd0, outstanding_loads}, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);

        // store: pop in the same cycle, request one cycle later
        step(); set_store(32'h1006, 4'b1100, 32'hABCD0000); #1;
        chk("st_pop", {31'd0, lsq_pop}, 32'd1);
        step(); drive_idle(); #1;
        chk("st_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("st_req_addr", mem_req_addr, 32'h1004);
        chk("st_req_rnw", {31'd0, mem_req_rnw}, 32'd0);
        chk("st_req_be", {28'd0, mem_req_be}, 32'hC);
        chk("st_req_wdata", mem_req_wdata, 32'hABCD0000);

        // LB at offset 3
        step(); set_load(3'd5, 3'b000, 32'h2003); #1;
        chk("lb_pop", {31'd0, lsq_pop}, 32'd1);
        step(); drive_idle(); #1;
        chk("lb_req_addr", mem_req_addr, 32'h2000);
        chk("lb_req_be", {28'd0, mem_req_be}, 32'hF);
        step(); respond(32'h80FFFFFF);
        step(); drive_idle(); #1;
        chk("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("lb_wb_id", {29'd0, wb_id}, 32'd5);
        chk("lb_wb_data", wb_data, 32'hFFFFFF80);
        step(); #1;
        chk("lb_wb_pulse", {31'd0, wb_valid}, 32'd0);

        // LHU at offset 2
        step(); set_load(3'd2, 3'b101, 32'h2002);
        step(); drive_idle();
        step(); respond(32'h80011234);
        step(); drive_idle(); #1;
        chk("lhu_wb_id", {29'd0, wb_id}, 32'd2);
        chk("lhu_wb_data", wb_data, 32'h00008001);

        // back-pressure for 3 cycles
        step(); mem_req_ready = 0; set_load(3'd1, 3'b010, 32'h3000); #1;
        chk("stall_first_pop", {31'd0, lsq_pop}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(); set_store(32'h4000, 4'hF, 32'h11111111); #1;
            chk("stall_pop", {31'd0, lsq_pop}, 32'd0);
            chk("stall_addr", mem_req_addr, 32'h3000);
            chk("stall_rnw", {31'd0, mem_req_rnw}, 32'd1);
        end
        step(); mem_req_ready = 1; #1;
        chk("stall_release_pop", {31'd0, lsq_pop}, 32'd1);
        step(); drive_idle(); #1;
        chk("stall_next_addr", mem_req_addr, 32'h4000);
        step(); respond(32'hDEADBEEF);
        step(); drive_idle(); #1;
        chk("lw_wb_data", wb_data, 32'hDEADBEEF);

        // fill the tracker
        for (int k = 0; k < 4; k++) begin
            step(); set_load(3'(k), 3'b010, 32'h100 + 32'(4 * k));
        end
        step(); set_load(3'd4, 3'b010, 32'h200); #1;
        chk("full_pop", {31'd0, lsq_pop}, 32'd0);
        chk("full_count", {29'd0, outstanding_loads}, 32'd4);
        step(); set_store(32'h300, 4'h1, 32'hAA); #1;
        chk("full_store_pop", {31'd0, lsq_pop}, 32'd1);
        step(); set_load(3'd4, 3'b010, 32'h200); respond(32'h10); #1;
        chk("no_bypass_pop", {31'd0, lsq_pop}, 32'd0);
        step(); mem_rvalid = 0; #1;
        chk("after_resp_count", {29'd0, outstanding_loads}, 32'd3);
        chk("after_resp_pop", {31'd0, lsq_pop}, 32'd1);
        chk("order_id0", {29'd0, wb_id}, 32'd0);

        // simultaneous push and retire, across pointer wrap
        step(); drive_idle(); respond(32'h11);
        step(); set_load(3'd5, 3'b010, 32'h204); respond(32'h12); #1;
        chk("order_id1", {29'd0, wb_id}, 32'd1);
        chk("sim_count_a", {29'd0, outstanding_loads}, 32'd3);
        step(); set_load(3'd6, 3'b010, 32'h208); respond(32'h13); #1;
        chk("order_id2", {29'd0, wb_id}, 32'd2);
        chk("sim_count_b", {29'd0, outstanding_loads}, 32'd3);
        step(); set_load(3'd7, 3'b010, 32'h20C); respond(32'h14); #1;
        chk("order_id3", {29'd0, wb_id}, 32'd3);
        step(); drive_idle(); respond(32'h15); #1;
        chk("order_id4", {29'd0, wb_id}, 32'd4);
        chk("sim_count_c", {29'd0, outstanding_loads}, 32'd3);
        step(); respond(32'h16); #1;
        chk("order_id5", {29'd0, wb_id}, 32'd5);
        step(); respond(32'h17); #1;
        chk("order_id6", {29'd0, wb_id}, 32'd6);
        step(); drive_idle(); #1;
        chk("order_id7", {29'd0, wb_id}, 32'd7);
        chk("drain_count", {29'd0, outstanding_loads}, 32'd0);

        // stray response, then reset with loads in flight
        step(); respond(32'h99);
        step(); drive_idle(); #1;
        chk("stray_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("stray_error", {31'd0, resp_error}, 32'd1);
        step(); set_load(3'd1, 3'b010, 32'h500);
        step(); set_load(3'd2, 3'b010, 32'h504);
        step(); drive_idle(); mem_req_ready = 0; #1;
        chk("pre_rst_count", {29'd0, outstanding_loads}, 32'd2);
        chk("pre_rst_error", {31'd0, resp_error}, 32'd1);
        chk("pre_rst_req_valid", {31'd0, mem_req_valid}, 32'd1);
        step(); rst = 1;
        step(); rst = 0; mem_req_ready = 1; #1;
        chk("post_rst_count", {29'd0, outstanding_loads}, 32'd0);
        chk("post_rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("post_rst_error", {31'd0, resp_error}, 32'd0);
        step(); respond(32'h55);
        step(); drive_idle(); #1;
        chk("late_resp_error", {31'd0, resp_error}, 32'd1);
        chk("late_resp_wb", {31'd0, wb_valid}, 32'd0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/lsq_request_issuer.md
Name: lsq_request_issuer

Overview:
- Consumer end of the load/store queue output port.
- Pops one load or store per cycle from the LSQ, registers it as a single-entry memory request and drives it onto the data-memory request handshake.
- Tracks outstanding loads in order and aligns and sign-extends returned load data.
- Presents each load result with its instruction ID to the writeback stage.

Parameters:
- ID_WIDTH, 3, width of the instruction ID carried with each load.
- MAX_OUTSTANDING_LOADS, 4, depth of the in-order load tracking FIFO. Power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lsq_valid  in  1  LSQ has an entry ready
- lsq_load  in  1  entry is a load
- lsq_store  in  1  entry is a store
- lsq_addr  in  32  byte address
- lsq_be  in  4  store byte enables, already lane-aligned
- lsq_fn3  in  3  RISC-V funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- lsq_data  in  32  store data, already lane-aligned
- lsq_id  in  ID_WIDTH  load ID
- lsq_pop  out  1  entry consumed this cycle
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_rnw  out  1  1 = read, 0 = write
- mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_req_be  out  4  write byte enables; 4'b1111 for reads
- mem_req_wdata  out  32  write data
- mem_rvalid  in  1  read data returned, in request order
- mem_rdata  in  32  read word
- wb_valid  out  1  load result valid (single-cycle pulse)
- wb_id  out  ID_WIDTH  load ID
- wb_data  out  32  aligned, extended load result
- outstanding_loads  out  $clog2(MAX_OUTSTANDING_LOADS)+1  count of loads popped but not yet written back
- resp_error  out  1  sticky flag: mem_rvalid seen with no load tracked

Behaviour:
- Reset: mem_req_valid=0, lsq_pop=0, wb_valid=0, outstanding_loads=0, resp_error=0.
  - Request register, tracking FIFO pointers and counter are cleared.
  - Reset mid-operation discards any pending request and all tracked loads; responses arriving later set resp_error.
- Request register (req_valid):
  - can_accept = ~req_valid | (mem_req_valid & mem_req_ready).
  - load_ok = outstanding_loads < MAX_OUTSTANDING_LOADS. No same-cycle bypass from a retiring response.
  - lsq_pop = lsq_valid & can_accept & (lsq_store | load_ok). This is combinational from inputs and registered state.
  - On pop, the request register loads the entry and req_valid=1 in the next cycle. Pop-to-mem_req_valid latency is 1 cycle.
  - Back-to-back issue is allowed when mem_req_ready=1, giving 1 request per cycle throughput.
  - mem_req_* are held stable while mem_req_valid & ~mem_req_ready.
- Load tracking:
  - On a load pop, push {lsq_id, lsq_fn3, lsq_addr[1:0]} into the tracking FIFO and increment the counter.
  - On mem_rvalid with the FIFO non-empty, pop the head and decrement the counter.
  - A simultaneous push and pop leaves the count unchanged.
  - FIFO pointers wrap modulo MAX_OUTSTANDING_LOADS.
  - The counter reaches exactly MAX_OUTSTANDING_LOADS when full; lsq_pop of loads is blocked while full, stores are still popped.
- Response path:
  - The cycle after mem_rvalid, wb_valid=1 with wb_id from the FIFO head.
  - wb_data = mem_rdata >> (8*offset), then extended per fn3:
    - 000: sign-extend byte
    - 100: zero-extend byte
    - 001: sign-extend halfword
    - 101: zero-extend halfword
    - 010: full word
  - Misaligned halfword (offset=3) is not checked; result is the shifted value.
- mem_rvalid with the FIFO empty: ignored, no wb_valid; resp_error set until reset.
- lsq_load and lsq_store both 0 or both 1 with lsq_valid: illegal; behaviour undefined, covered by an assertion.

Test Plan:
- Reset then idle -> all outputs 0; lsq_valid=1 store addr=0x1006, be=4'b1100, data=0xABCD0000 -> lsq_pop same cycle; next cycle mem_req_valid=1, addr=0x1004, rnw=0, be=4'b1100, wdata=0xABCD0000.
- Load LB id=5 addr=0x2003; mem_rvalid with rdata=0x80FFFFFF -> one cycle later wb_valid=1, wb_id=5, wb_data=0xFFFFFF80.
  - Repeat as LHU at addr=0x2002, rdata=0x8001_1234 -> wb_data=0x00008001.
- mem_req_ready held 0 for 3 cycles with a load pending -> mem_req_* stable, lsq_pop=0 while the register is full; ready=1 -> next entry popped the same cycle.
- Issue 4 loads with no responses -> outstanding_loads=4, 5th load not popped, a following store is popped.
  - One mem_rvalid -> count 3, load popped the next cycle.
  - wb_id order matches issue order across FIFO wrap (8 loads total).
- Same cycle: load pop and mem_rvalid -> outstanding_loads unchanged.
- mem_rvalid with no outstanding loads -> no wb_valid, resp_error=1 until rst; rst asserted with 2 loads outstanding -> count 0, mem_req_valid 0 next cycle.
